// File: rtl/val2_pkg.sv
// Shared types for the Val2 iterative shifter: shift opcodes and sequencer states.
package val2_pkg;

   localparam logic [1:0] SHOP_LSL = 2'b00;
   localparam logic [1:0] SHOP_LSR = 2'b01;
   localparam logic [1:0] SHOP_ASR = 2'b10;
   localparam logic [1:0] SHOP_ROR = 2'b11;

   typedef enum logic [1:0] {
      LSL = SHOP_LSL,
      LSR = SHOP_LSR,
      ASR = SHOP_ASR,
      ROR = SHOP_ROR
   } shift_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/val2_shift_step.sv
// One narrow shifter step: moves acc by 0..BITS_PER_CYCLE positions for the given opcode.
module val2_shift_step
   import val2_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [31:0] acc,
   input  shift_op_t   op,
   input  logic [2:0]  step,
   output logic [31:0] acc_next
);

   function automatic logic [31:0] shift_by(input logic [31:0] a, input shift_op_t sop,
                                            input int unsigned s);
      logic signed [31:0] sa;
      sa = a;
      case (sop)
         LSL:     return a << s;
         LSR:     return a >> s;
         ASR:     return sa >>> s;
         default: return (a >> s) | (a << (32 - s));
      endcase
   endfunction

   // Only the small set of legal step sizes is built, each a fixed-distance shift.
   always_comb begin
      acc_next = acc;
      for (int s = 1; s <= BITS_PER_CYCLE; s++) begin
         if (step == 3'(s)) acc_next = shift_by(acc, op, s);
      end
   end

endmodule

// File: rtl/val2_iter_shifter.sv
// EXE-stage Val2 sequencer: decodes the shifter operand, iterates a narrow shifter, and
// returns the result over a valid/ready handshake while stalling the pipeline.
module val2_iter_shifter
   import val2_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        memrw,
   input  logic        imm,
   input  logic [31:0] val_rm,
   input  logic [11:0] shift_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] val2,
   output logic        unsupported,
   output logic        stall
);

   state_t      state, state_nxt;
   shift_op_t   op, dec_op;
   logic [31:0] acc, acc_step, dec_acc;
   logic [4:0]  remaining, dec_amt;
   logic [2:0]  step;
   logic        unsup_q, dec_unsup, accept;

   assign in_ready    = (state == IDLE);
   assign stall       = (state != IDLE);
   assign out_valid   = (state == DONE);
   assign val2        = acc;
   assign unsupported = unsup_q;
   assign accept      = in_valid && in_ready && !flush;

   // Clamp keeps the 5-bit remaining counter from wrapping on the final step.
   assign step = (remaining < 5'(BITS_PER_CYCLE)) ? remaining[2:0] : 3'(BITS_PER_CYCLE);

   always_comb begin
      dec_acc   = val_rm;
      dec_op    = shift_op_t'(shift_operand[6:5]);
      dec_amt   = shift_operand[11:7];
      dec_unsup = 1'b0;
      if (memrw) begin
         dec_acc = {20'b0, shift_operand};
         dec_op  = LSL;
         dec_amt = '0;
      end else if (imm) begin
         dec_acc = {24'b0, shift_operand[7:0]};
         dec_op  = ROR;
         dec_amt = {shift_operand[11:8], 1'b0};
      end else if (shift_operand[4]) begin
         dec_acc   = '0;
         dec_op    = LSL;
         dec_amt   = '0;
         dec_unsup = 1'b1;
      end
   end

   val2_shift_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
      .acc      (acc),
      .op       (op),
      .step     (step),
      .acc_next (acc_step)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (dec_amt == 5'd0) ? DONE : SHIFT;
         SHIFT:   if (remaining == 5'(step)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Flush only redirects the FSM; acc deliberately keeps its partial value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         op        <= LSL;
         unsup_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc       <= dec_acc;
            op        <= dec_op;
            remaining <= dec_amt;
            unsup_q   <= dec_unsup;
         end else if (state == SHIFT && !flush) begin
            acc       <= acc_step;
            remaining <= remaining - 5'(step);
         end
      end
   end

endmodule

// File: tb/tb_val2_iter_shifter.sv
// Scoreboard bench for val2_iter_shifter: expected results queued at issue, compared on handshake.
module tb_val2_iter_shifter;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, memrw, imm, out_ready;
   logic [31:0] val_rm;
   logic [11:0] shift_operand;
   logic        in_ready, out_valid, unsupported, stall;
   logic [31:0] val2;
   logic        o4_ready, o4_valid, o4_unsup, o4_stall;
   logic [31:0] o4_val2;

   typedef struct {
      logic [31:0] val;
      logic        uns;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          ov_cyc = 0;
   int          o4_cyc = 0;
   logic        ov_prev = 1'b0;
   logic        o4_prev = 1'b0;
   logic [31:0] o4_cap = '0;

   always #5 clk = ~clk;

   val2_iter_shifter #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .memrw(memrw), .imm(imm), .val_rm(val_rm), .shift_operand(shift_operand),
      .out_valid(out_valid), .out_ready(out_ready), .val2(val2),
      .unsupported(unsupported), .stall(stall)
   );

   val2_iter_shifter #(.BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o4_ready),
      .memrw(memrw), .imm(imm), .val_rm(val_rm), .shift_operand(shift_operand),
      .out_valid(o4_valid), .out_ready(out_ready), .val2(o4_val2),
      .unsupported(o4_unsup), .stall(o4_stall)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] sop,
                                         input int n);
      case (sop)
         2'b00:   return a << n;
         2'b01:   return a >> n;
         2'b10:   return 32'($signed(a) >>> n);
         default: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Everything is sampled mid-cycle; inputs change only 1 time unit after the rising edge.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         ov_prev = 1'b0;
         o4_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) ov_cyc = cyc;
         if (o4_valid && !o4_prev) begin
            o4_cyc = cyc;
            o4_cap = o4_val2;
         end
         ov_prev = out_valid;
         o4_prev = o4_valid;
         if (out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("val2", val2, e.val);
               chk("unsupported", {31'b0, unsupported}, {31'b0, e.uns});
               chk("latency", 32'(ov_cyc - acc_cyc + 1), 32'(e.lat));
            end
         end
         if (in_valid && in_ready && !flush) acc_cyc = cyc + 1;
      end
   end

   task automatic launch(input logic m, input logic i, input logic [31:0] rm,
                         input logic [11:0] so);
      bit got;
      memrw = m; imm = i; val_rm = rm; shift_operand = so; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!got) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && in_ready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         chk("done_timeout", 32'd1, 32'd0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic m, input logic i, input logic [31:0] rm,
                        input logic [11:0] so, input logic [31:0] ev, input logic eu,
                        input int el);
      exp_t e;
      e.val = ev; e.uns = eu; e.lat = el;
      sb.push_back(e);
      launch(m, i, rm, so);
      wait_idle();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; memrw = 1'b0; imm = 1'b0;
      out_ready = 1'b1; val_rm = '0; shift_operand = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_val2", val2, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_unsup", {31'b0, unsupported}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst4_ready", {29'b0, o4_ready, o4_stall, o4_unsup}, 32'b100);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(1'b1, 1'b0, 32'hFFFF_FFFF, 12'hABC, 32'h0000_0ABC, 1'b0, 1);
      issue(1'b0, 1'b1, 32'h0, 12'h2FF, 32'hF000_000F, 1'b0, 5);
      issue(1'b1, 1'b1, 32'h0, 12'h2FF, 32'h0000_02FF, 1'b0, 1);
      issue(1'b0, 1'b0, 32'h1, 12'hF80, 32'h8000_0000, 1'b0, 32);
      chk("lat_bpc4", 32'(o4_cyc - acc_cyc + 1), 32'd9);
      chk("val2_bpc4", o4_cap, 32'h8000_0000);
      issue(1'b0, 1'b0, 32'h8000_0000, 12'h240, 32'hF800_0000, 1'b0, 5);
      issue(1'b0, 1'b0, 32'h8000_0000, 12'h220, 32'h0800_0000, 1'b0, 5);

      begin
         exp_t e;
         bit seen;
         e.val = 32'hF000_0000; e.uns = 1'b0; e.lat = 5;
         sb.push_back(e);
         out_ready = 1'b0;
         launch(1'b0, 1'b0, 32'hF, 12'h260);
         seen = 1'b0;
         for (int k = 0; k < 50; k++) begin
            if (out_valid) begin
               seen = 1'b1;
               break;
            end
            @(posedge clk); #1;
         end
         chk("hold_seen", {31'b0, seen}, 32'd1);
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_val2", val2, 32'hF000_0000);
            chk("hold_flags", {28'b0, out_valid, in_ready, stall, unsupported}, 32'b1010);
         end
         out_ready = 1'b1;
         wait_idle();
      end

      issue(1'b0, 1'b0, 32'hDEAD_BEEF, 12'h010, 32'h0, 1'b1, 1);
      issue(1'b0, 1'b1, 32'h0, 12'h110, 32'h0000_0004, 1'b0, 3);

      for (int r = 0; r < 6; r++) begin
         logic [31:0] rm;
         logic [11:0] so;
         rm = $urandom;
         so = 12'($urandom);
         so[4] = 1'b0;
         issue(1'b0, 1'b0, rm, so, model(rm, so[6:5], int'(so[11:7])), 1'b0,
               1 + int'(so[11:7]));
      end

      // Abort in SHIFT: must not produce a result.
      launch(1'b0, 1'b0, 32'h1, 12'hF80);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_flags", {29'b0, out_valid, in_ready, stall}, 32'b010);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_no_out", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset mid-operation, after an unsupported result left state behind.
      issue(1'b0, 1'b0, 32'h0, 12'h010, 32'h0, 1'b1, 1);
      launch(1'b0, 1'b0, 32'h1, 12'hF80);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_stall", {31'b0, stall}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_val2", val2, 32'h0);
      chk("arst_flags", {28'b0, out_valid, unsupported, in_ready, stall}, 32'b0010);
      @(posedge clk); #1;
      rst = 1'b0;

      issue(1'b1, 1'b0, 32'h0, 12'h123, 32'h0000_0123, 1'b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
